// File: rtl/i8mac_seq_if.sv
// ----------------------------------------------------------------------------
// i8mac_seq_if
// Groups the signals of the MAC-lane sequencer:
//   layer control : start, depth, n_out, in_base, fil_base
//   memory/MAC in : rdy, acvalid
//   MAC control   : acl, aen, ivalid, ch
//   memory reads  : in_addr, fil_addr
//   status        : busy, done
// Modports:
//   master - the surrounding control/memory/MAC side
//   slave  - the sequencer
// ----------------------------------------------------------------------------
interface i8mac_seq_if #(
    parameter int AW = 20,
    parameter int DW = 12,
    parameter int NW = 12
);
    logic          start;
    logic [DW-1:0] depth;
    logic [NW-1:0] n_out;
    logic [AW-1:0] in_base;
    logic [AW-1:0] fil_base;
    logic          rdy;
    logic          acvalid;
    logic          acl;
    logic          aen;
    logic          ivalid;
    logic [AW-1:0] in_addr;
    logic [AW-1:0] fil_addr;
    logic [NW-1:0] ch;
    logic          busy;
    logic          done;

    modport master (
        output start, depth, n_out, in_base, fil_base, rdy, acvalid,
        input  acl, aen, ivalid, in_addr, fil_addr, ch, busy, done
    );

    modport slave (
        input  start, depth, n_out, in_base, fil_base, rdy, acvalid,
        output acl, aen, ivalid, in_addr, fil_addr, ch, busy, done
    );
endinterface

// File: rtl/i8mac_seq.sv
// ----------------------------------------------------------------------------
// i8mac_seq
// Sequencer for one int8 per-channel quantized MAC lane. On start it walks
// n_out output channels; each channel gets one accumulator clear, depth MAC
// beats with input/filter read addresses, then DRAIN idle cycles so the MAC
// can finish bias add and requantize. Returned acvalid pulses are counted and
// done pulses once every channel result is back.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - i8mac_seq_if slave modport (control, MAC and memory signals)
// ----------------------------------------------------------------------------
module i8mac_seq #(
    parameter int AW    = 20,
    parameter int DW    = 12,
    parameter int NW    = 12,
    parameter int DRAIN = 3
) (
    input  logic        clk,
    input  logic        reset,
    i8mac_seq_if.slave  bus
);
    localparam int CW = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_WAITV, S_DONE
    } state_t;

    state_t        state_q,    state_d;
    logic [DW-1:0] depth_q,    depth_d;
    logic [NW-1:0] n_out_q,    n_out_d;
    logic [AW-1:0] in_base_q,  in_base_d;
    logic [AW-1:0] fil_base_q, fil_base_d;
    logic [DW-1:0] k_q,        k_d;
    logic [NW-1:0] ch_q,       ch_d;
    // Running ch*depth, so the filter address needs an adder, not a multiplier.
    logic [AW-1:0] ch_off_q,   ch_off_d;
    logic [CW-1:0] drn_q,      drn_d;
    logic [NW-1:0] ret_q,      ret_d;
    logic [NW-1:0] ret_next;
    logic          busy;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of its neighbours.
        if (reset) begin
            state_q    <= S_IDLE;
            depth_q    <= '0;
            n_out_q    <= '0;
            in_base_q  <= '0;
            fil_base_q <= '0;
            k_q        <= '0;
            ch_q       <= '0;
            ch_off_q   <= '0;
            drn_q      <= '0;
            ret_q      <= '0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            n_out_q    <= n_out_d;
            in_base_q  <= in_base_d;
            fil_base_q <= fil_base_d;
            k_q        <= k_d;
            ch_q       <= ch_d;
            ch_off_q   <= ch_off_d;
            drn_q      <= drn_d;
            ret_q      <= ret_d;
        end
    end

    assign busy = (state_q != S_IDLE);

    // A pulse in the same cycle as the WAITV check is counted first.
    assign ret_next = ret_q + NW'(bus.acvalid && busy);

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        depth_d    = depth_q;
        n_out_d    = n_out_q;
        in_base_d  = in_base_q;
        fil_base_d = fil_base_q;
        k_d        = k_q;
        ch_d       = ch_q;
        ch_off_d   = ch_off_q;
        drn_d      = drn_q;
        ret_d      = ret_next;
        bus.acl    = 1'b0;
        bus.aen    = 1'b0;
        bus.ivalid = 1'b0;
        bus.done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    depth_d    = bus.depth;
                    n_out_d    = bus.n_out;
                    in_base_d  = bus.in_base;
                    fil_base_d = bus.fil_base;
                    k_d        = '0;
                    ch_d       = '0;
                    ch_off_d   = '0;
                    drn_d      = '0;
                    ret_d      = '0;
                    state_d    = (bus.depth == '0 || bus.n_out == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                bus.acl = 1'b1;
                if (bus.rdy) begin
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bus.aen    = 1'b1;
                bus.ivalid = 1'b1;
                if (bus.rdy) begin
                    k_d = k_q + 1'b1;
                    if (k_q == depth_q - 1'b1) begin
                        drn_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.rdy) begin
                    drn_d = drn_q + 1'b1;
                    if (drn_q == CW'(DRAIN - 1)) begin
                        if (ch_q == n_out_q - 1'b1) begin
                            state_d = S_WAITV;
                        end else begin
                            ch_d     = ch_q + 1'b1;
                            ch_off_d = ch_off_q + AW'(depth_q);
                            state_d  = S_CLEAR;
                        end
                    end
                end
            end
            S_WAITV: begin
                if (ret_next >= n_out_q) state_d = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address outputs are combinational from registered counters; they are
    // only meaningful in RUN but always resolve to defined values.
    assign bus.in_addr  = in_base_q + AW'(k_q);
    assign bus.fil_addr = fil_base_q + ch_off_q + AW'(k_q);
    assign bus.ch       = ch_q;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_i8mac_seq.sv
// ----------------------------------------------------------------------------
// tb_i8mac_seq
// Directed stimulus for i8mac_seq. Expected clears, MAC beats and done pulses
// are queued by the stimulus; a negedge monitor pops and compares whenever the
// sequencer presents one.
// ----------------------------------------------------------------------------
module tb_i8mac_seq;
    localparam int AW = 20;
    localparam int DW = 12;
    localparam int NW = 12;

    typedef struct { int cyc; int ch; int in_a; int fil; } beat_t;
    typedef struct { int cyc; int ch; int gap; } clr_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   beats_seen = 0;
    int   dones_seen = 0;
    int   last_beat_cyc = 0;
    bit   mon_en = 1'b0;
    bit   rdy_mode = 1'b0;

    beat_t beat_q[$];
    clr_t  clr_q[$];
    int    done_q[$];

    i8mac_seq_if #(.AW(AW), .DW(DW), .NW(NW)) bus ();

    i8mac_seq #(.AW(AW), .DW(DW), .NW(NW), .DRAIN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start_run(input int d, input int n, input int ib, input int fb, output int s);
        bus.depth    = d[DW-1:0];
        bus.n_out    = n[NW-1:0];
        bus.in_base  = ib[AW-1:0];
        bus.fil_base = fb[AW-1:0];
        bus.start    = 1'b1;
        s = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_acv();
        bus.acvalid = 1'b1;
        tick();
        bus.acvalid = 1'b0;
    endtask

    task automatic push_beat(input int c, input int ch, input int ia, input int fa);
        beat_t b;
        b.cyc = c; b.ch = ch; b.in_a = ia & 32'hFFFFF; b.fil = fa & 32'hFFFFF;
        beat_q.push_back(b);
    endtask

    task automatic push_clr(input int c, input int ch, input int gap);
        clr_t e;
        e.cyc = c; e.ch = ch; e.gap = gap;
        clr_q.push_back(e);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int b = 0;
        while (beats_seen < target && b < budget) begin tick(); b++; end
        check("beat_count", beats_seen, target);
    endtask

    task automatic wait_dones(input int target, input int budget);
        int b = 0;
        while (dones_seen < target && b < budget) begin tick(); b++; end
        check("done_count", dones_seen, target);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_beat_q_left"}, beat_q.size(), 0);
        check({tag, "_clr_q_left"},  clr_q.size(),  0);
        check({tag, "_done_q_left"}, done_q.size(), 0);
    endtask

    // depth=4, n_out=2, bases 0x100/0x200, rdy high: exact cycle timing.
    task automatic run_basic(input string tag);
        int s;
        int d0;
        d0 = dones_seen;
        start_run(4, 2, 'h100, 'h200, s);
        push_clr(s + 1, 0, 0);
        push_clr(s + 9, 1, 0);
        for (int k = 0; k < 4; k++) push_beat(s + 2 + k,  0, 'h100 + k, 'h200 + k);
        for (int k = 0; k < 4; k++) push_beat(s + 10 + k, 1, 'h100 + k, 'h204 + k);
        done_q.push_back(s + 19);
        wait_until(s + 8);
        pulse_acv();
        wait_until(s + 18);
        pulse_acv();
        check({tag, "_busy_in_done"}, bus.busy, 1'b1);
        wait_until(s + 20);
        check({tag, "_busy_after_done"}, bus.busy, 1'b0);
        wait_dones(d0 + 1, 10);
        check_drained(tag);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ivalid && bus.rdy) begin
                check("beat_expected", 32'(beat_q.size() != 0), 1);
                if (beat_q.size() != 0) begin
                    beat_t e;
                    e = beat_q.pop_front();
                    check("beat_ch",  bus.ch, e.ch);
                    check("in_addr",  bus.in_addr, e.in_a);
                    check("fil_addr", bus.fil_addr, e.fil);
                    if (e.cyc >= 0) check("beat_cycle", cyc, e.cyc);
                end
                beats_seen++;
                last_beat_cyc = cyc;
            end else if (bus.ivalid && beat_q.size() != 0) begin
                check("in_addr_hold",  bus.in_addr,  beat_q[0].in_a);
                check("fil_addr_hold", bus.fil_addr, beat_q[0].fil);
            end
            if (bus.acl && bus.rdy) begin
                check("clear_expected", 32'(clr_q.size() != 0), 1);
                if (clr_q.size() != 0) begin
                    clr_t e;
                    e = clr_q.pop_front();
                    check("clear_ch", bus.ch, e.ch);
                    if (e.cyc >= 0) check("clear_cycle", cyc, e.cyc);
                    if (e.gap > 0) check("drain_gap", cyc - last_beat_cyc, e.gap);
                end
            end
            if (bus.acl && bus.aen) check("acl_aen_exclusive", 1'b1, 1'b0);
            if (bus.done) begin
                check("done_expected", 32'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    int dc;
                    dc = done_q.pop_front();
                    if (dc >= 0) check("done_cycle", cyc, dc);
                end
                dones_seen++;
            end
        end
    end

    // rdy driver: tied high, or alternating every cycle.
    initial begin
        bus.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rdy = rdy_mode ? ~bus.rdy : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int d0;
        int b0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.acvalid  = 1'b0;
        bus.depth    = '0;
        bus.n_out    = '0;
        bus.in_base  = '0;
        bus.fil_base = '0;
        repeat (3) tick();

        // Reset state.
        check("rst_acl",    bus.acl,    1'b0);
        check("rst_aen",    bus.aen,    1'b0);
        check("rst_ivalid", bus.ivalid, 1'b0);
        check("rst_busy",   bus.busy,   1'b0);
        check("rst_done",   bus.done,   1'b0);
        check("rst_ch",     bus.ch,     0);
        check("rst_in",     bus.in_addr,  0);
        check("rst_fil",    bus.fil_addr, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        run_basic("basic");
        repeat (3) tick();

        // Alternating rdy: 4 qualified beats per channel, addresses hold,
        // DRAIN plus CLEAR span 4 rdy cycles = 8 clocks after the last beat.
        rdy_mode = 1'b1;
        d0 = dones_seen;
        b0 = beats_seen;
        start_run(4, 2, 'h100, 'h200, s);
        push_clr(-1, 0, 0);
        push_clr(-1, 1, 8);
        for (int k = 0; k < 4; k++) push_beat(-1, 0, 'h100 + k, 'h200 + k);
        for (int k = 0; k < 4; k++) push_beat(-1, 1, 'h100 + k, 'h204 + k);
        done_q.push_back(-1);
        wait_beats(b0 + 8, 200);
        pulse_acv();
        tick();
        pulse_acv();
        wait_dones(d0 + 1, 100);
        check_drained("toggle");
        rdy_mode = 1'b0;
        repeat (3) tick();

        // depth=0 and n_out=0: straight to DONE, no clear or beat.
        d0 = dones_seen;
        start_run(0, 2, 'h10, 'h20, s);
        done_q.push_back(s + 1);
        check("zd_busy", bus.busy, 1'b1);
        wait_until(s + 2);
        check("zd_busy_after", bus.busy, 1'b0);
        wait_dones(d0 + 1, 5);
        d0 = dones_seen;
        start_run(4, 0, 'h10, 'h20, s);
        done_q.push_back(s + 1);
        wait_until(s + 4);
        wait_dones(d0 + 1, 5);
        check_drained("zero");

        // Second start during RUN is ignored.
        d0 = dones_seen;
        start_run(4, 1, 'h40, 'h80, s);
        push_clr(s + 1, 0, 0);
        for (int k = 0; k < 4; k++) push_beat(s + 2 + k, 0, 'h40 + k, 'h80 + k);
        done_q.push_back(s + 10);
        wait_until(s + 3);
        bus.depth = 12'd7; bus.n_out = 12'd3; bus.in_base = 20'h999; bus.fil_base = 20'h777;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_until(s + 9);
        pulse_acv();
        wait_until(s + 30);
        check("restart_single_done", dones_seen, d0 + 1);
        check_drained("restart");

        // Reset in the third RUN cycle, then a fresh run.
        start_run(8, 1, 'h300, 'h500, s);
        push_clr(s + 1, 0, 0);
        for (int k = 0; k < 3; k++) push_beat(s + 2 + k, 0, 'h300 + k, 'h500 + k);
        wait_until(s + 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_aen",  bus.aen,  1'b0);
        check("abort_acl",  bus.acl,  1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_ch",   bus.ch,   0);
        repeat (10) tick();
        check_drained("abort");
        run_basic("rerun");

        // Filter and input address wrap at 2^AW.
        d0 = dones_seen;
        start_run(4, 1, 'hFFFFF, 'hFFFFE, s);
        push_clr(s + 1, 0, 0);
        push_beat(s + 2, 0, 'hFFFFF, 'hFFFFE);
        push_beat(s + 3, 0, 'h00000, 'hFFFFF);
        push_beat(s + 4, 0, 'h00001, 'h00000);
        push_beat(s + 5, 0, 'h00002, 'h00001);
        done_q.push_back(s + 10);
        wait_until(s + 9);
        pulse_acv();
        wait_dones(d0 + 1, 10);
        check_drained("wrap");

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
